// File: rtl/common.sv
// Shared decode-stage types: the packed control word and the default
// (XLEN=32) ID-stage trace record layout.
package common;

    // Packed ID-stage control word, shared by decode and trace logic.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
        logic       ecall;
    } control_type;

    localparam int ID_TRACE_DROP_W = 16;

    // One captured ID-stage output record for the default 32-bit core.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        control_type ctrl;
    } id_trace_rec_t;

endpackage

// File: rtl/id_trace_ptr.sv
// Wrap-around write/read pointers and occupancy counter for the ID trace
// buffer. Decides whether a push lands in storage, and whether it
// costs a record (dropped newest or overwritten oldest).
module id_trace_ptr #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic             overwrite_i,
    output logic             wr_en_o,
    output logic             lost_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, do_pop, grow;
    logic             wr_en, lost;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign do_pop = pop_i & ~empty;
    assign grow   = wr_en & ~lost;

    // Next pointers/count: a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        lost     = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i && (!full || do_pop)) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (push_i) begin
                lost = 1'b1;
                if (overwrite_i) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (grow && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!grow && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer/count state; reset empties the buffer without touching storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_en_o  = wr_en;
    assign lost_o   = lost;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/id_trace_buffer.sv
// Circular capture buffer for ID-stage output records, drained through a
// valid/ready port. Full-buffer policy: drop newest or overwrite oldest.
module id_trace_buffer
    import common::*;
#(
    parameter int XLEN      = 32,
    parameter int RID_W     = 5,
    parameter int CTRL_W    = $bits(control_type),
    parameter int DEPTH     = 8,
    parameter int OVERWRITE = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       capture_en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [RID_W-1:0]           in_rd,
    input  logic [XLEN-1:0]            in_rs1_data,
    input  logic [XLEN-1:0]            in_rs2_data,
    input  logic [XLEN-1:0]            in_imm,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [RID_W-1:0]           out_rd,
    output logic [XLEN-1:0]            out_rs1_data,
    output logic [XLEN-1:0]            out_rs2_data,
    output logic [XLEN-1:0]            out_imm,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [ID_TRACE_DROP_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [RID_W-1:0]  rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } rec_t;

    function automatic logic [ID_TRACE_DROP_W-1:0] sat_inc(input logic [ID_TRACE_DROP_W-1:0] v);
        return (v == '1) ? v : v + ID_TRACE_DROP_W'(1);
    endfunction

    rec_t                       mem_q [DEPTH];
    rec_t                       wr_rec, head;
    logic                       push, pop, wr_en, lost;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count_w;
    logic                       overflow_q, overflow_d;
    logic [ID_TRACE_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    assign push   = in_valid & capture_en;
    assign pop    = out_valid & out_ready;
    assign wr_rec = '{pc: in_pc, rd: in_rd, rs1_data: in_rs1_data,
                      rs2_data: in_rs2_data, imm: in_imm, ctrl: in_ctrl};

    id_trace_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .overwrite_i (OVERWRITE != 0),
        .wr_en_o     (wr_en),
        .lost_o      (lost),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .count_o     (count_w)
    );

    // Record storage: written only when the pointer logic accepts the push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_rec;
        end
    end

    // Loss bookkeeping: sticky flag plus saturating counter, both cleared by flush.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (lost) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Loss bookkeeping registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign head         = mem_q[rd_ptr];
    assign out_valid    = (count_w != '0);
    assign out_pc       = head.pc;
    assign out_rd       = head.rd;
    assign out_rs1_data = head.rs1_data;
    assign out_rs2_data = head.rs2_data;
    assign out_imm      = head.imm;
    assign out_ctrl     = head.ctrl;
    assign count        = count_w;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_id_trace_buffer.sv
// Bench for id_trace_buffer: one drop-newest and one overwrite-oldest
// instance driven by the same stimulus, checked against queue models.
module tb_id_trace_buffer;
    import common::*;

    localparam int XLEN   = 32;
    localparam int RID_W  = 5;
    localparam int CTRL_W = $bits(control_type);
    localparam int DEPTH  = 8;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [RID_W-1:0]  rd;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } rec_t;

    typedef struct {
        logic        v;
        logic        en;
        logic        rdy;
        logic [31:0] pc;
        int          exp_cnt;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, capture_en, flush, in_valid, out_ready;
    rec_t in_rec;

    logic              v0, v1, ovf0, ovf1;
    logic [XLEN-1:0]   pc0, pc1, rs10, rs11, rs20, rs21, imm0, imm1;
    logic [RID_W-1:0]  rd0, rd1;
    logic [CTRL_W-1:0] ctrl0, ctrl1;
    logic [3:0]        cnt0, cnt1;
    logic [15:0]       drp0, drp1;

    id_trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(0)) u0 (
        .clk(clk), .rstn(rstn), .capture_en(capture_en), .flush(flush),
        .in_valid(in_valid), .in_pc(in_rec.pc), .in_rd(in_rec.rd),
        .in_rs1_data(in_rec.rs1), .in_rs2_data(in_rec.rs2), .in_imm(in_rec.imm),
        .in_ctrl(in_rec.ctrl), .out_valid(v0), .out_ready(out_ready),
        .out_pc(pc0), .out_rd(rd0), .out_rs1_data(rs10), .out_rs2_data(rs20),
        .out_imm(imm0), .out_ctrl(ctrl0), .count(cnt0), .overflow(ovf0),
        .drop_cnt(drp0));

    id_trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(1)) u1 (
        .clk(clk), .rstn(rstn), .capture_en(capture_en), .flush(flush),
        .in_valid(in_valid), .in_pc(in_rec.pc), .in_rd(in_rec.rd),
        .in_rs1_data(in_rec.rs1), .in_rs2_data(in_rec.rs2), .in_imm(in_rec.imm),
        .in_ctrl(in_rec.ctrl), .out_valid(v1), .out_ready(out_ready),
        .out_pc(pc1), .out_rd(rd1), .out_rs1_data(rs11), .out_rs2_data(rs21),
        .out_imm(imm1), .out_ctrl(ctrl1), .count(cnt1), .overflow(ovf1),
        .drop_cnt(drp1));

    int compared = 0;
    int mismatched = 0;

    rec_t        mq [2][$];
    int unsigned mdrop [2];
    bit          movf [2];

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pc);
        rec_t r;
        r.pc   = pc;
        r.rd   = pc[6:2];
        r.rs1  = ~pc;
        r.rs2  = pc ^ 32'h5A5A_0000;
        r.imm  = {pc[15:0], pc[31:16]};
        r.ctrl = pc[CTRL_W+1:2];
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mdrop[m] = 0;
            movf[m]  = 1'b0;
        end
    endtask

    // Queue-level reference: pop the head if asked, then admit the push.
    task automatic model_step();
        rec_t tmp;
        for (int m = 0; m < 2; m++) begin
            if (flush) begin
                mq[m].delete();
                mdrop[m] = 0;
                movf[m]  = 1'b0;
            end else begin
                if (out_ready && mq[m].size() != 0) tmp = mq[m].pop_front();
                if (in_valid && capture_en) begin
                    if (mq[m].size() < DEPTH) begin
                        mq[m].push_back(in_rec);
                    end else begin
                        if (m == 1) begin
                            tmp = mq[m].pop_front();
                            mq[m].push_back(in_rec);
                        end
                        movf[m] = 1'b1;
                        if (mdrop[m] < 32'hFFFF) mdrop[m]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic        a_v, a_o;
        logic [3:0]  a_c;
        logic [15:0] a_d;
        rec_t        a_h;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin
                a_v = v0; a_o = ovf0; a_c = cnt0; a_d = drp0;
                a_h = {pc0, rd0, rs10, rs20, imm0, ctrl0};
            end else begin
                a_v = v1; a_o = ovf1; a_c = cnt1; a_d = drp1;
                a_h = {pc1, rd1, rs11, rs21, imm1, ctrl1};
            end
            check($sformatf("count[ow%0d]", m), 160'(a_c), 160'(mq[m].size()));
            check($sformatf("out_valid[ow%0d]", m), 160'(a_v), 160'(mq[m].size() != 0));
            check($sformatf("overflow[ow%0d]", m), 160'(a_o), 160'(movf[m]));
            check($sformatf("drop_cnt[ow%0d]", m), 160'(a_d), 160'(mdrop[m]));
            if (mq[m].size() != 0)
                check($sformatf("head[ow%0d]", m), 160'(a_h), 160'(mq[m][0]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic v, input logic en, input logic rdy,
                          input logic fl, input logic [31:0] pc);
        in_valid   = v;
        capture_en = en;
        out_ready  = rdy;
        flush      = fl;
        in_rec     = mk(pc);
    endtask

    vec_t        tbl [9];
    logic [31:0] exp0 [8];
    logic [31:0] exp1 [8];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h100, 1, 1'b1, 32'h100};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h104, 2, 1'b1, 32'h100};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h108, 3, 1'b1, 32'h100};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h000, 2, 1'b1, 32'h104};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h000, 1, 1'b1, 32'h108};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h000, 0, 1'b0, 32'h000};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h200, 0, 1'b0, 32'h000};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h300, 1, 1'b1, 32'h300};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h000, 0, 1'b0, 32'h000};
        for (int i = 0; i < 7; i++) exp0[i] = 32'h1000 + 32'(4 * (i + 1));
        exp0[7] = 32'h1028;
        for (int i = 0; i < 7; i++) exp1[i] = 32'h1000 + 32'(4 * (i + 3));
        exp1[7] = 32'h1028;

        // Reset held with a valid record presented: nothing may be captured.
        rstn = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        #1;
        check("rst_count", 160'(cnt0), 160'(0));
        check("rst_valid", 160'(v1), 160'(0));
        check("rst_overflow", 160'(ovf0), 160'(0));
        check_all();

        // First edge after release accepts the push.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h50);
        step();
        check("first_push_count", 160'(cnt0), 160'(1));
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step();

        // Directed table: ordered fill/drain, capture_en gating, empty push+pop.
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].v, tbl[i].en, tbl[i].rdy, 1'b0, tbl[i].pc);
            step();
            check($sformatf("tbl%0d_count", i), 160'(cnt0), 160'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_valid", i), 160'(v0), 160'(tbl[i].exp_v));
            if (tbl[i].exp_v)
                check($sformatf("tbl%0d_pc", i), 160'(pc0), 160'(tbl[i].exp_pc));
        end

        // Ten pushes into an 8-deep buffer with the consumer stalled.
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(4 * i));
            step();
        end
        check("fill_count_ow0", 160'(cnt0), 160'(8));
        check("fill_drop_ow0", 160'(drp0), 160'(2));
        check("fill_ovf_ow0", 160'(ovf0), 160'(1));
        check("fill_head_ow0", 160'(pc0), 160'(32'h1000));
        check("fill_count_ow1", 160'(cnt1), 160'(8));
        check("fill_drop_ow1", 160'(drp1), 160'(2));
        check("fill_head_ow1", 160'(pc1), 160'(32'h1008));

        // Full buffer, push and pop together: no loss.
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h1028);
        step();
        check("pp_count_ow0", 160'(cnt0), 160'(8));
        check("pp_drop_ow0", 160'(drp0), 160'(2));
        check("pp_count_ow1", 160'(cnt1), 160'(8));
        check("pp_drop_ow1", 160'(drp1), 160'(2));

        // Drain order; the record pushed alongside the pop comes out last.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_ow0", i), 160'(pc0), 160'(exp0[i]));
            check($sformatf("drain%0d_ow1", i), 160'(pc1), 160'(exp1[i]));
            step();
        end
        check("drained_valid", 160'(v0), 160'(0));

        // Flush with a simultaneous push: flush wins and clears loss state.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h2000);
        step();
        check("flush_count", 160'(cnt0), 160'(0));
        check("flush_drop", 160'(drp1), 160'(0));
        check("flush_ovf", 160'(ovf1), 160'(0));

        // Randomised traffic with varying consumer pressure.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                capture_en = ($urandom_range(0, 7) != 0);
                out_ready  = ($urandom_range(0, 5) < blk);
                flush      = ($urandom_range(0, 63) == 0);
                in_rec     = {$urandom(), 5'($urandom()), $urandom(), $urandom(),
                              $urandom(), CTRL_W'($urandom())};
                step();
            end
        end

        // Reset mid-drain empties the buffer without a clock edge.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h3000 + 32'(4 * i));
            step();
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        #3 rstn = 1'b0;
        #1;
        check("async_rst_valid_ow0", 160'(v0), 160'(0));
        check("async_rst_valid_ow1", 160'(v1), 160'(0));
        check("async_rst_count", 160'(cnt0), 160'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
